// File: rtl/decode_thread_arbiter.sv
// Round-robin arbiter that shares one decode stage between two fetch threads and
// registers the selected instruction bundle. Optional perf counters: DECODE_ARB_PERF_COUNTERS_EN.
module decode_thread_arbiter #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PrimOpcodeSize          = 6,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64
) (
    input  logic                               clock_i,
    input  logic                               reset_i,

    input  logic                               t0_valid_i,
    input  logic [instructionWidth-1:0]        t0_instruction_i,
    input  logic [addressWidth-1:0]            t0_address_i,
    input  logic                               t0_is64Bit_i,
    input  logic [PidSize-1:0]                 t0_pid_i,
    input  logic [TidSize-1:0]                 t0_tid_i,
    output logic                               t0_ready_o,

    input  logic                               t1_valid_i,
    input  logic [instructionWidth-1:0]        t1_instruction_i,
    input  logic [addressWidth-1:0]            t1_address_i,
    input  logic                               t1_is64Bit_i,
    input  logic [PidSize-1:0]                 t1_pid_i,
    input  logic [TidSize-1:0]                 t1_tid_i,
    output logic                               t1_ready_o,

    input  logic [1:0]                         flush_i,
    input  logic                               stall_i,

    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic                               threadSel_o
`ifdef DECODE_ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]                        grantCnt0_o,
    output logic [31:0]                        grantCnt1_o,
    output logic [31:0]                        stallCnt_o
`endif
);

    logic [1:0] validVec;
    logic [1:0] effValid;
    logic [1:0] ready;
    logic [1:0] transfer;
    logic       canAccept;
    logic       grant;
    logic       lastGrant;
    logic       anyTransfer;
    logic       selNext;
    logic [instructionCounterWidth-1:0] majCntView [2];

    assign validVec  = {t1_valid_i, t0_valid_i};
    // A flushed thread drops out of arbitration so the other can still win this cycle.
    assign effValid  = validVec & ~flush_i;
    assign canAccept = !enable_o || !stall_i;

    always_comb begin
        grant = !lastGrant;
        case (effValid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = !lastGrant;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gThread
            logic [instructionCounterWidth-1:0] majCnt;

            assign ready[gi]      = reset_i && canAccept && (grant == 1'(gi)) && !flush_i[gi];
            assign transfer[gi]   = ready[gi] && validVec[gi];
            assign majCntView[gi] = majCnt;

            // Major IDs survive flushes; only reset clears them.
            always_ff @(posedge clock_i) begin
                if (!reset_i) begin
                    majCnt <= '0;
                end else if (transfer[gi]) begin
                    majCnt <= majCnt + instructionCounterWidth'(1);
                end
            end
        end
    endgenerate

    assign t0_ready_o  = ready[0];
    assign t1_ready_o  = ready[1];
    assign anyTransfer = |transfer;
    assign selNext     = transfer[1];

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            enable_o             <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            is64Bit_o            <= 1'b0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
            threadSel_o          <= 1'b0;
            lastGrant            <= 1'b1;
        end else if (anyTransfer) begin
            enable_o             <= 1'b1;
            instruction_o        <= selNext ? t1_instruction_i : t0_instruction_i;
            instructionAddress_o <= selNext ? t1_address_i : t0_address_i;
            is64Bit_o            <= selNext ? t1_is64Bit_i : t0_is64Bit_i;
            instructionPid_o     <= selNext ? t1_pid_i : t0_pid_i;
            instructionTid_o     <= selNext ? t1_tid_i : t0_tid_i;
            instructionMajId_o   <= majCntView[selNext];
            threadSel_o          <= selNext;
            lastGrant            <= selNext;
        end else if (canAccept || flush_i[threadSel_o]) begin
            // Flushing the owning thread kills the held bundle even while stalled.
            enable_o <= 1'b0;
        end
    end

    // Opcode is instruction bits 0..5 in big-endian numbering, i.e. the top bits here.
    assign instructionOpcode_o = instruction_o[instructionWidth-1 -: PrimOpcodeSize];

`ifdef DECODE_ARB_PERF_COUNTERS_EN
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            grantCnt0_o <= '0;
            grantCnt1_o <= '0;
            stallCnt_o  <= '0;
        end else begin
            if (transfer[0]) grantCnt0_o <= grantCnt0_o + 32'd1;
            if (transfer[1]) grantCnt1_o <= grantCnt1_o + 32'd1;
            if (enable_o && stall_i) stallCnt_o <= stallCnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_thread_arbiter.sv
// Randomized bench for decode_thread_arbiter against a cycle-level behavioural model;
// a second instance with a 3-bit major counter exercises counter wrap.
module tb_decode_thread_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        t0Valid, t1Valid;
    logic [31:0] t0Instr, t1Instr;
    logic [63:0] t0Addr, t1Addr;
    logic        t0Is64, t1Is64;
    logic [19:0] t0Pid, t1Pid;
    logic [15:0] t0Tid, t1Tid;
    logic [1:0]  flush;
    logic        stall;

    logic        t0Ready, t1Ready, enable, threadSel, is64;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [63:0] addr, majId;
    logic [19:0] pid;
    logic [15:0] tid;

    logic        sT0Ready, sT1Ready, sEnable, sThreadSel, sIs64;
    logic [31:0] sInstr;
    logic [5:0]  sOpcode;
    logic [63:0] sAddr;
    logic [2:0]  sMajId;
    logic [19:0] sPid;
    logic [15:0] sTid;
`ifdef DECODE_ARB_PERF_COUNTERS_EN
    logic [31:0] gc0, gc1, sc, sGc0, sGc1, sSc;
`endif

    decode_thread_arbiter dut (
        .clock_i(clk), .reset_i(rstN),
        .t0_valid_i(t0Valid), .t0_instruction_i(t0Instr), .t0_address_i(t0Addr),
        .t0_is64Bit_i(t0Is64), .t0_pid_i(t0Pid), .t0_tid_i(t0Tid), .t0_ready_o(t0Ready),
        .t1_valid_i(t1Valid), .t1_instruction_i(t1Instr), .t1_address_i(t1Addr),
        .t1_is64Bit_i(t1Is64), .t1_pid_i(t1Pid), .t1_tid_i(t1Tid), .t1_ready_o(t1Ready),
        .flush_i(flush), .stall_i(stall),
        .enable_o(enable), .instruction_o(instr), .instructionOpcode_o(opcode),
        .instructionAddress_o(addr), .is64Bit_o(is64), .instructionPid_o(pid),
        .instructionTid_o(tid), .instructionMajId_o(majId), .threadSel_o(threadSel)
`ifdef DECODE_ARB_PERF_COUNTERS_EN
        , .grantCnt0_o(gc0), .grantCnt1_o(gc1), .stallCnt_o(sc)
`endif
    );

    decode_thread_arbiter #(.instructionCounterWidth(3)) dutSmall (
        .clock_i(clk), .reset_i(rstN),
        .t0_valid_i(t0Valid), .t0_instruction_i(t0Instr), .t0_address_i(t0Addr),
        .t0_is64Bit_i(t0Is64), .t0_pid_i(t0Pid), .t0_tid_i(t0Tid), .t0_ready_o(sT0Ready),
        .t1_valid_i(t1Valid), .t1_instruction_i(t1Instr), .t1_address_i(t1Addr),
        .t1_is64Bit_i(t1Is64), .t1_pid_i(t1Pid), .t1_tid_i(t1Tid), .t1_ready_o(sT1Ready),
        .flush_i(flush), .stall_i(stall),
        .enable_o(sEnable), .instruction_o(sInstr), .instructionOpcode_o(sOpcode),
        .instructionAddress_o(sAddr), .is64Bit_o(sIs64), .instructionPid_o(sPid),
        .instructionTid_o(sTid), .instructionMajId_o(sMajId), .threadSel_o(sThreadSel)
`ifdef DECODE_ARB_PERF_COUNTERS_EN
        , .grantCnt0_o(sGc0), .grantCnt1_o(sGc1), .stallCnt_o(sSc)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: the expected decoder-facing bundle plus arbitration history.
    bit          eEn, eSel, eIs64, eLast;
    logic [31:0] eInstr;
    logic [63:0] eAddr, eMaj;
    logic [19:0] ePid;
    logic [15:0] eTid;
    logic [63:0] eCnt [2];

    // Returns the thread the spec's grant rules pick among unflushed valid threads, or -1.
    function automatic int pickThread();
        bit [1:0] live;
        live = {t1Valid, t0Valid} & ~flush;
        if (live == 2'b11) return eLast ? 0 : 1;
        if (live[0]) return 0;
        if (live[1]) return 1;
        return -1;
    endfunction

    task automatic checkReady();
        bit acc;
        int g;
        logic [1:0] got;
        acc = !eEn || !stall;
        g   = pickThread();
        got = {t1Ready, t0Ready};
        checks++;
        if (got == 2'b11) begin
            errors++;
            $display("FAIL readyOneHot observed=%b expected=at most one", got);
        end
        for (int n = 0; n < 2; n++) begin
            if (!rstN || !acc || flush[n]) checkVal($sformatf("ready%0dLow", n), 64'(got[n]), 64'd0);
            else if (g >= 0) checkVal($sformatf("ready%0dGrant", n), 64'(got[n]), 64'(g == n));
        end
    endtask

    task automatic stepModel();
        bit acc;
        int g;
        if (!rstN) begin
            eEn = 0; eSel = 0; eIs64 = 0; eLast = 1;
            eInstr = '0; eAddr = '0; eMaj = '0; ePid = '0; eTid = '0;
            eCnt[0] = '0; eCnt[1] = '0;
            return;
        end
        acc = !eEn || !stall;
        g   = pickThread();
        if (acc && g >= 0) begin
            eEn    = 1;
            eSel   = (g == 1);
            eLast  = eSel;
            eInstr = eSel ? t1Instr : t0Instr;
            eAddr  = eSel ? t1Addr  : t0Addr;
            eIs64  = eSel ? t1Is64  : t0Is64;
            ePid   = eSel ? t1Pid   : t0Pid;
            eTid   = eSel ? t1Tid   : t0Tid;
            eMaj   = eCnt[g];
            eCnt[g] = eCnt[g] + 64'd1;
            $display("xfer thread=%0d majId=%0d instr=%h", g, eMaj, eInstr);
        end else if (acc) begin
            eEn = 0;
        end else if (eEn && flush[eSel]) begin
            eEn = 0;
        end
    endtask

    task automatic checkOutputs();
        checkVal("enable",    64'(enable),    64'(eEn));
        checkVal("threadSel", 64'(threadSel), 64'(eSel));
        checkVal("instr",     64'(instr),     64'(eInstr));
        checkVal("opcode",    64'(opcode),    64'(eInstr[31:26]));
        checkVal("addr",      addr,           eAddr);
        checkVal("is64",      64'(is64),      64'(eIs64));
        checkVal("pid",       64'(pid),       64'(ePid));
        checkVal("tid",       64'(tid),       64'(eTid));
        checkVal("majId",     majId,          eMaj);
        checkVal("majIdWrap", 64'(sMajId),    64'(eMaj[2:0]));
    endtask

    task automatic cycle(input bit rst, input bit v0, input bit v1, input logic [1:0] fl,
                         input bit st, input logic [31:0] i0);
        @(negedge clk);
        rstN = rst; t0Valid = v0; t1Valid = v1; flush = fl; stall = st;
        t0Instr = i0;        t1Instr = $urandom;
        t0Addr  = {$urandom, $urandom}; t1Addr = {$urandom, $urandom};
        t0Is64  = 1'($urandom); t1Is64 = 1'($urandom);
        t0Pid   = 20'($urandom); t1Pid  = 20'($urandom);
        t0Tid   = 16'($urandom); t1Tid  = 16'($urandom);
        #1;
        checkReady();
        stepModel();
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    initial begin
        logic [31:0] held;
        rstN = 0; t0Valid = 0; t1Valid = 0; flush = 0; stall = 0;
        t0Instr = 0; t1Instr = 0; t0Addr = 0; t1Addr = 0; t0Is64 = 0; t1Is64 = 0;
        t0Pid = 0; t1Pid = 0; t0Tid = 0; t1Tid = 0;

        // Thread 0 alone: sequential major IDs, thread 1 never ready.
        cycle(0, 0, 0, 2'b00, 0, 32'h0);
        cycle(0, 0, 0, 2'b00, 0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 1, 0, 2'b00, 0, 32'h4800_0000 + 32'(k));
            checkVal("t0OnlyInstr", 64'(instr), 64'(32'h4800_0000 + 32'(k)));
            checkVal("t0OnlyMaj",   majId,      64'(k - 1));
        end

        // Both threads contending: strict alternation starting with thread 0.
        cycle(0, 0, 0, 2'b00, 0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            cycle(1, 1, 1, 2'b00, 0, $urandom);
            checkVal("altSel", 64'(threadSel), 64'(k % 2));
            checkVal("altMaj", majId,          64'(k / 2));
        end

        // Stall holds the bundle; the next transfer follows release.
        held = instr;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 1, 2'b00, 1, $urandom);
            checkVal("stallHold", 64'(instr), 64'(held));
        end
        cycle(1, 1, 1, 2'b00, 0, $urandom);
        checkVal("afterStallEn", 64'(enable), 64'd1);

        // Flush thread 1 while it owns a stalled bundle.
        cycle(0, 0, 0, 2'b00, 0, 32'h0);
        cycle(1, 1, 1, 2'b00, 0, $urandom);
        cycle(1, 1, 1, 2'b00, 0, $urandom);
        checkVal("ownerT1", 64'(threadSel), 64'd1);
        cycle(1, 1, 0, 2'b10, 1, $urandom);
        checkVal("flushDrop", 64'(enable), 64'd0);
        cycle(1, 1, 0, 2'b00, 1, $urandom);
        checkVal("flushT0Sel", 64'(threadSel), 64'd0);
        checkVal("flushT0En",  64'(enable),    64'd1);

        // Reset mid-stream under stall, then thread 0 wins first contention.
        cycle(0, 1, 1, 2'b00, 1, $urandom);
        checkVal("midRstEn", 64'(enable), 64'd0);
        cycle(1, 1, 1, 2'b00, 0, $urandom);
        checkVal("postRstSel", 64'(threadSel), 64'd0);

        // Random traffic, long enough to wrap the small instance's counters repeatedly.
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom_range(99) >= 2),
                  ($urandom_range(9) < 7), ($urandom_range(9) < 7),
                  {($urandom_range(9) == 0), ($urandom_range(9) == 0)},
                  ($urandom_range(9) < 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_thread_arbiter.md
# decode_thread_arbiter

Shares one format-specific decode stage, such as the B-format decoder, between two hardware threads. Each cycle it selects one thread's fetched instruction with a round-robin grant and assigns it a per-thread major ID. It registers the instruction into the decoder-facing `*_i` bundle and holds that bundle stable while the decoder stalls. It sits between the per-thread fetch buffers and the decode stage, and is the only source of `enable_i`/`instructionMajId_i` for the decoders.

## Interface
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction word width
- PrimOpcodeSize, 6, primary opcode width (instruction bits [0:5])
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID counter width
- clock_i  in  1  clock, rising edge
- reset_i  in  1  synchronous, active-low reset
- tN_valid_i  in  1  thread N (N=0,1) has an instruction
- tN_instruction_i  in  instructionWidth  instruction word
- tN_address_i  in  addressWidth  instruction address
- tN_is64Bit_i  in  1  64-bit mode
- tN_pid_i / tN_tid_i  in  PidSize / TidSize  process / thread ID
- tN_ready_o  out  1  arbiter accepts thread N this cycle
- flush_i  in  2  per-thread flush, bit 0 = thread 0
- stall_i  in  1  decode stage cannot take a new instruction
- enable_o  out  1  output bundle valid, drives decoder enable_i
- instruction_o  out  instructionWidth  selected instruction
- instructionOpcode_o  out  PrimOpcodeSize  instruction_o[0:5]
- instructionAddress_o  out  addressWidth
- is64Bit_o  out  1
- instructionPid_o / instructionTid_o  out  PidSize / TidSize
- instructionMajId_o  out  instructionCounterWidth  per-thread major ID
- threadSel_o  out  1  thread that owns the current output

## Operation
- canAccept = !enable_o || !stall_i.
- Grant selection:
  - Only one thread valid: grant that thread.
  - Both valid: grant the thread != lastGrant.
- tN_ready_o = canAccept && grant==N && !flush_i[N]. This is combinational and at most one ready is high per cycle.
- Transfer on tN_valid_i && tN_ready_o. On a transfer:
  - The output bundle loads thread N's fields.
  - instructionMajId_o = majCnt[N].
  - majCnt[N] increments, wrapping modulo 2^instructionCounterWidth.
  - lastGrant <= N, threadSel_o <= N, enable_o <= 1.
- No transfer and canAccept: enable_o <= 0; data outputs hold their last values.
- enable_o && stall_i: every output holds, bit-exact.
- Flush of thread N:
  - Thread N is not granted in the flush cycle.
  - If enable_o && threadSel_o==N, enable_o <= 0 next cycle, even when stall_i is high.
  - The other thread is unaffected and may be granted in the same cycle.
  - majCnt is never reset by flush.
- Flush of both threads: no grant, and enable_o <= 0.
- Reset (reset_i==0 at a rising edge) takes priority over every other input:
  - enable_o, all data outputs, threadSel_o, both majCnt = 0.
  - lastGrant = 1, so thread 0 wins the first contention.
  - tN_ready_o = 0 while reset_i is low.

## Timing
- One-cycle latency from transfer edge to enable_o high.
- Sustained throughput is one instruction per cycle when stall_i is low.
- With both threads valid and no stall, grants alternate 0,1,0,1.
- A stall asserted in the same cycle as enable_o holds the bundle. The next transfer happens in the first cycle with stall_i low, and the new bundle appears on the following edge.
- Major IDs are strictly sequential per thread. Counters are independent between threads.

## Configuration
- DECODE_ARB_PERF_COUNTERS_EN defined:
  - Adds outputs grantCnt0_o, grantCnt1_o and stallCnt_o, each 32 bits.
  - grantCntN_o increments on each thread N transfer.
  - stallCnt_o increments each cycle with enable_o && stall_i.
  - All three wrap, clear on reset, and ignore flush.
- Undefined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset, then t0 only valid for 4 cycles with instructions 0x48000001..04 -> enable_o high one cycle after each, majId 0,1,2,3, threadSel_o=0, t1_ready_o=0.
- Both threads valid for 6 cycles after reset -> grants 0,1,0,1,0,1; instructionMajId_o 0,0,1,1,2,2.
- Transfer then stall_i=1 for 3 cycles -> outputs held bit-exact, both ready_o=0. stall_i=0 -> next pending instruction is on the outputs one cycle later.
- Output owned by t1 under stall, flush_i=2'b10 -> enable_o low next cycle. A valid t0 in the flush cycle is not blocked by thread selection; it is accepted once canAccept holds.
- Preload majCnt[0]=2^64-1 via 2^64-1 transfers (or force), one more t0 transfer -> majId 0xFFFF_FFFF_FFFF_FFFF, next transfer majId 0.
- reset_i low mid-stream with enable_o high and stall_i high -> next edge all outputs 0, counters 0. After release, t0 wins first contention.
